// File: rtl/ram_arbiter_if.sv
// Request/acknowledge bundle between the two bus masters and the RAM arbiter.
// Port 0 is the processor and port 1 is the secondary master; rdata is shared by both ports.
interface ram_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  ack0, ack1, rdata
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output ack0, ack1, rdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter and strobe sequencer for a shared single-port synchronous RAM.
// Define RAM_ARB_RR_EN for round-robin contention; the default build uses fixed priority (port 0 wins).
module ram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  ram_arbiter_if.slave      bus,
  output logic              n_mem_cs,
  output logic              n_mem_rw,
  output logic              n_mem_oe,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data
);

`ifdef RAM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;

  state_t            state;
  logic              last_grant;
  logic              gnt_id;
  logic              lat_we;
  logic              drv_en;
  logic [DATA_W-1:0] drv_dat;
  logic [DATA_W-1:0] rdata_q;
  logic              ack0_q;
  logic              ack1_q;
  logic              win;

  // Contention picks the port that did not win last time only in round-robin mode.
  always_comb begin
    win = 1'b0;
    if (bus.req0 && bus.req1)
      win = RR_EN & ~last_grant;
    else
      win = ~bus.req0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      n_mem_cs   <= 1'b1;
      n_mem_rw   <= 1'b1;
      n_mem_oe   <= 1'b1;
      mem_addr   <= '0;
      drv_en     <= 1'b0;
      drv_dat    <= '0;
      rdata_q    <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      last_grant <= 1'b1;
      gnt_id     <= 1'b0;
      lat_we     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ack0_q <= 1'b0;
          ack1_q <= 1'b0;
          if (bus.req0 || bus.req1) begin
            gnt_id     <= win;
            last_grant <= win;
            lat_we     <= win ? bus.we1 : bus.we0;
            n_mem_cs   <= 1'b0;
            mem_addr   <= win ? bus.addr1 : bus.addr0;
            if (win ? bus.we1 : bus.we0) begin
              n_mem_rw <= 1'b0;
              n_mem_oe <= 1'b1;
              drv_en   <= 1'b1;
              drv_dat  <= win ? bus.wdata1 : bus.wdata0;
            end else begin
              n_mem_rw <= 1'b1;
              n_mem_oe <= 1'b0;
              drv_en   <= 1'b0;
            end
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (lat_we) begin
            n_mem_cs <= 1'b1;
            n_mem_rw <= 1'b1;
            n_mem_oe <= 1'b1;
            drv_en   <= 1'b0;
            ack0_q   <= ~gnt_id;
            ack1_q   <= gnt_id;
            state    <= DONE;
          end else begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          // The RAM presents the word registered at the end of ACCESS.
          rdata_q  <= mem_data;
          n_mem_cs <= 1'b1;
          n_mem_rw <= 1'b1;
          n_mem_oe <= 1'b1;
          ack0_q   <= ~gnt_id;
          ack1_q   <= gnt_id;
          state    <= DONE;
        end
        DONE: begin
          ack0_q <= 1'b0;
          ack1_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_data  = drv_en ? drv_dat : {DATA_W{1'bz}};
  assign bus.ack0  = ack0_q;
  assign bus.ack1  = ack1_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a synchronous RAM model on the strobes, directed transactions,
// and an ack monitor that pops hand-computed expectations (port, read data) from a queue.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       n_mem_cs;
  logic       n_mem_rw;
  logic       n_mem_oe;
  logic [7:0] mem_addr;
  wire  [7:0] mem_data;

  ram_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  ram_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .n_mem_cs (n_mem_cs),
    .n_mem_rw (n_mem_rw),
    .n_mem_oe (n_mem_oe),
    .mem_addr (mem_addr),
    .mem_data (mem_data)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: write or register read word on a selected edge, drive while oe low.
  logic [7:0] mem [256];
  logic [7:0] rd_q;
  always @(posedge clk) begin
    if (!n_mem_cs) begin
      if (!n_mem_rw) mem[mem_addr] <= mem_data;
      else           rd_q <= mem[mem_addr];
    end
  end
  assign mem_data = (!n_mem_cs && !n_mem_oe) ? rd_q : 8'bzzzzzzzz;

  typedef struct packed {
    logic       port;
    logic       rd;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic port, input logic rd, input logic [7:0] data);
    exp_t e;
    e.port = port;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Ack monitor: every ack must match the next expected completion.
  always @(negedge clk) begin
    if (bus.ack0 || bus.ack1) begin
      tests++;
      if (bus.ack0 && bus.ack1) begin
        fails++;
        $display("FAIL ack_both: ack0=%0b ack1=%0b expected one-hot", bus.ack0, bus.ack1);
      end else if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL ack_spurious: ack0=%0b ack1=%0b expected none", bus.ack0, bus.ack1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.ack1 !== e.port) begin
          fails++;
          $display("FAIL ack_port: got port %0d expected port %0d", bus.ack1, e.port);
        end else if (e.rd) begin
          tests++;
          if (bus.rdata !== e.data) begin
            fails++;
            $display("FAIL rdata: got 0x%0h expected 0x%0h (port %0d)", bus.rdata, e.data, e.port);
          end
        end
      end
    end
  end

  task automatic set_req(input int p, input logic v, input logic we, input logic [7:0] a, input logic [7:0] d);
    if (p == 0) begin
      bus.req0 = v; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = v; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  // Waits for the port's ack (bounded), checks latency if exp_lat > 0, then drops req in IDLE.
  task automatic wait_ack(input int p, input int exp_lat);
    int  n = 0;
    logic seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      seen = (p == 0) ? bus.ack0 : bus.ack1;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL ack_timeout: port %0d got no ack within %0d cycles expected ack", p, n);
    end else if (exp_lat > 0) begin
      check($sformatf("latency_p%0d", p), n, exp_lat);
    end
    @(posedge clk);
    #1;
    if (p == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
  endtask

  task automatic do_txn(input int p, input logic we, input logic [7:0] a, input logic [7:0] d, input int exp_lat);
    set_req(p, 1'b1, we, a, d);
    wait_ack(p, exp_lat);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);

    // Reset held two cycles while port 0 requests a write.
    set_req(0, 1'b1, 1'b1, 8'h08, 8'h5A);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_n_cs", n_mem_cs, 1);
    check("rst_n_rw", n_mem_rw, 1);
    check("rst_n_oe", n_mem_oe, 1);
    check("rst_addr", mem_addr, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_ack", {bus.ack1, bus.ack0}, 0);
    push(1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    wait_ack(0, 3);
    check("mem_08", mem[8'h08], 8'h5A);

    // Write then read on port 0.
    push(1'b0, 1'b0, 8'h00);
    do_txn(0, 1'b1, 8'h10, 8'hA5, 3);
    push(1'b0, 1'b1, 8'hA5);
    do_txn(0, 1'b0, 8'h10, 8'h00, 4);
    check("mem_10", mem[8'h10], 8'hA5);

    // Port 1 rises during port 0's CAPTURE; granted in the IDLE after ack0.
    push(1'b0, 1'b1, 8'hA5);
    push(1'b1, 1'b0, 8'h00);
    set_req(0, 1'b1, 1'b0, 8'h10, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #1;
    set_req(1, 1'b1, 1'b1, 8'h40, 8'h77);
    wait_ack(0, 0);
    wait_ack(1, 3);
    check("mem_40", mem[8'h40], 8'h77);
    check("rdata_hold", bus.rdata, 8'hA5);

    // Contention: both ports write then read.
    pulse_reset();
`ifdef RAM_ARB_RR_EN
    push(1'b0, 1'b0, 8'h00);
    push(1'b1, 1'b0, 8'h00);
    push(1'b0, 1'b1, 8'h11);
    push(1'b1, 1'b1, 8'h22);
`else
    push(1'b0, 1'b0, 8'h00);
    push(1'b0, 1'b1, 8'h11);
    push(1'b1, 1'b0, 8'h00);
    push(1'b1, 1'b1, 8'h22);
`endif
    fork
      begin
        do_txn(0, 1'b1, 8'h20, 8'h11, 0);
        do_txn(0, 1'b0, 8'h20, 8'h00, 0);
      end
      begin
        do_txn(1, 1'b1, 8'h21, 8'h22, 0);
        do_txn(1, 1'b0, 8'h21, 8'h00, 0);
      end
    join
    check("mem_20", mem[8'h20], 8'h11);
    check("mem_21", mem[8'h21], 8'h22);

    // Port 0 keeps requesting; port 1 waits (fixed) or interleaves (round-robin).
    pulse_reset();
`ifdef RAM_ARB_RR_EN
    push(1'b0, 1'b0, 8'h00);
    push(1'b1, 1'b1, 8'hA5);
    push(1'b0, 1'b0, 8'h00);
    push(1'b0, 1'b0, 8'h00);
`else
    push(1'b0, 1'b0, 8'h00);
    push(1'b0, 1'b0, 8'h00);
    push(1'b0, 1'b0, 8'h00);
    push(1'b1, 1'b1, 8'hA5);
`endif
    fork
      begin
        for (int i = 0; i < 3; i++)
          do_txn(0, 1'b1, 8'h30 + 8'(i), 8'h01 + 8'(i), 0);
      end
      do_txn(1, 1'b0, 8'h10, 8'h00, 0);
    join
    check("mem_32", mem[8'h32], 8'h03);

    // Reset during CAPTURE abandons the read.
    set_req(0, 1'b1, 1'b0, 8'h20, 8'h00);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rstcap_ack", {bus.ack1, bus.ack0}, 0);
    check("rstcap_rdata", bus.rdata, 0);
    check("rstcap_n_cs", n_mem_cs, 1);
    check("rstcap_n_oe", n_mem_oe, 1);
    check("rstcap_n_rw", n_mem_rw, 1);
    bus.req0 = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    check("exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter and strobe sequencer for the shared `single_port_sync_ram` data memory. It lets the MGT2_8R processor (port 0) and a second bus master such as a loader or DMA engine (port 1) share one RAM. It grants one requester at a time, drives the RAM's active-low `n_cs`/`n_rw`/`n_oe` strobes, address and tri-state data bus, and returns read data with a one-cycle acknowledge. In the SoC it sits between both masters and the RAM instance.

## Interface
- `ADDR_W`, 8, RAM address width.
- `DATA_W`, 8, RAM data width.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0`, `req1`  in  1  access request from port 0 / port 1; held high until the matching ack.
- `we0`, `we1`  in  1  1 = write, 0 = read; valid while req is high.
- `addr0`, `addr1`  in  ADDR_W  access address.
- `wdata0`, `wdata1`  in  DATA_W  write data.
- `ack0`, `ack1`  out  1  one-cycle completion pulse for port 0 / port 1.
- `rdata`  out  DATA_W  read data, shared; valid in the cycle ack0 or ack1 is high after a read.
- `n_mem_cs`  out  1  RAM chip select, active low.
- `n_mem_rw`  out  1  RAM read/not-write (0 = write).
- `n_mem_oe`  out  1  RAM output enable, active low.
- `mem_addr`  out  ADDR_W  RAM address.
- `mem_data`  inout  DATA_W  RAM data bus; driven only during a write access, otherwise high-Z.

## Operation
- All outputs are registered, and `mem_data` uses a registered drive enable.
- Reset values: `n_mem_cs`=1, `n_mem_rw`=1, `n_mem_oe`=1, `mem_addr`=0, `mem_data`=Z, `ack0`=`ack1`=0, `rdata`=0, state=IDLE, `last_grant`=1 (port 0 wins the first contention).
- The FSM has four states: IDLE, ACCESS, CAPTURE, DONE.
- **IDLE**
  - All strobes are high and `mem_data` is Z.
  - If any req is high, the arbiter picks a winner, latches its we/addr/wdata and port id, updates `last_grant`, and goes to ACCESS.
  - With no req, it stays in IDLE.
- **ACCESS** (1 cycle)
  - `n_mem_cs`=0 and `mem_addr`=latched address.
  - Write: `n_mem_rw`=0, `n_mem_oe`=1, `mem_data`=latched wdata. The RAM writes at the closing edge. Next state is DONE.
  - Read: `n_mem_rw`=1, `n_mem_oe`=0, `mem_data`=Z. Next state is CAPTURE.
- **CAPTURE** (read only, 1 cycle)
  - Strobes are held as in ACCESS.
  - `rdata` samples `mem_data` at the closing edge. Next state is DONE.
- **DONE** (1 cycle)
  - Strobes are high and `mem_data` is Z.
  - The ack of the granted port is high. Next state is IDLE.
- Arbitration is evaluated only in IDLE. A request arriving mid-transaction waits and is never dropped.
- A requester that keeps req high through its ack cycle is treated as a new request in the following IDLE cycle.
- The arbiter never drives `mem_data` while `n_mem_oe`=0. The drive enable changes only on IDLE/DONE boundaries, so there is no bus overlap.
- `rst` asserted in any state returns to reset values at the next edge. An in-flight transaction is abandoned with no ack, and a write in ACCESS may or may not have landed.

## Timing
- Request sampled high in IDLE at edge E0:
  - write: ACCESS in cycle E0–E1, ack in cycle E1–E2; 3 cycles per write including IDLE.
  - read: ACCESS E0–E1, CAPTURE E1–E2, ack + rdata E2–E3; 4 cycles per read.
- Back-to-back from one port: one IDLE cycle always separates transactions.
- `rdata` holds its last read value until the next CAPTURE. It is unchanged by writes.

## Configuration
- `RAM_ARB_RR_EN` defined: round-robin arbitration. On simultaneous req0 and req1 in IDLE, the port that did not hold `last_grant` wins.
- `RAM_ARB_RR_EN` undefined: fixed priority, port 0 always wins contention. In this mode `last_grant` is still updated but ignored.
- A lone requester is granted immediately in both modes.

## Test plan
- Reset: hold `rst` 2 cycles while req0 is high -> strobes all 1, `mem_data`=Z, no ack, state IDLE; release -> port 0 serviced.
- Write then read on port 0: write 0xA5 to 0x10, then read 0x10 -> ack0 on cycle 3 of the write; read ack0 on cycle 4 with `rdata`=0xA5; no ack1.
- Contention with `RAM_ARB_RR_EN`: req0 and req1 both held, writing 0x11→0x20 and 0x22→0x21, then held as reads -> grants alternate 0,1,0,1; RAM contents correct.
- Contention without the macro: req0 and req1 held continuously -> port 0 granted every transaction and port 1 starves; drop req0 -> port 1 granted on the next IDLE.
- Mid-transaction request: req1 rises during port 0's CAPTURE -> port 1 is not granted until after ack0, and is granted in the next IDLE.
- Reset mid-read: assert `rst` during CAPTURE -> no ack, `rdata`=0, strobes 1, `mem_data` Z at the next edge.
